// File: rtl/key_event_queue_if.sv
// Keyboard event queue bus: decoder-level inputs, control, and the event
// handshake toward the game FSM.
//   master : drives rx_ascii, rx_released, flush, ev_ready; observes ev_*/count/overflow
//   slave  : the queue itself
interface key_event_queue_if #(
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [7:0]       rx_ascii;
    logic             rx_released;
    logic             flush;
    logic             ev_ready;
    logic             ev_valid;
    logic [7:0]       ev_ascii;
    logic [CNT_W-1:0] count;
    logic             overflow;

    modport master (
        output rx_ascii, rx_released, flush, ev_ready,
        input  ev_valid, ev_ascii, count, overflow
    );

    modport slave (
        input  rx_ascii, rx_released, flush, ev_ready,
        output ev_valid, ev_ascii, count, overflow
    );
endinterface

// File: rtl/key_event_queue.sv
// key_event_queue: turns the PS/2 decoder's level outputs (current code plus
// released flag) into one event per key press, buffered in a DEPTH-entry FIFO
// and offered to the consumer over a valid/ready handshake.
//
// Ports:
//   clk     : system clock, rising edge
//   reset   : asynchronous, active-high
//   io_kbd  : key_event_queue_if.slave
//             rx_ascii/rx_released  decoder outputs (0x00 = unmapped key)
//             flush                 synchronous queue clear, wins over push/pop
//             ev_ready              consumer takes the head event
//             ev_valid/ev_ascii     head event (ev_ascii = 0x00 when empty)
//             count                 entries held
//             overflow              sticky, a press was dropped while full
//
// Optional feature macro: KEY_EVENT_CASE_FOLD_EN
//   defined   : A-Z (0x41-0x5A) are stored as lowercase (code + 0x20)
//   undefined : codes are stored unmodified
module key_event_queue #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                clk,
    input  logic                reset,
    key_event_queue_if.slave    io_kbd
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic             r_prev_released;
    logic [7:0]       r_prev_ascii;
    logic [7:0]       r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_overflow;

    logic             w_press;
    logic             w_full;
    logic             w_empty;
    logic             w_pop;
    logic             w_push;
    logic [7:0]       w_store;

    // Press detection and handshake qualifiers
    always_comb begin
        w_press = 1'b0;
        w_full  = 1'b0;
        w_empty = 1'b0;
        w_pop   = 1'b0;
        w_push  = 1'b0;

        w_press = !io_kbd.rx_released && (io_kbd.rx_ascii != 8'h00) &&
                  (r_prev_released || (io_kbd.rx_ascii != r_prev_ascii));
        w_full  = (r_count == CNT_W'(DEPTH));
        w_empty = (r_count == '0);
        w_pop   = !w_empty && io_kbd.ev_ready;
        // A full queue can still accept when the head leaves in the same cycle
        w_push  = w_press && (!w_full || w_pop);
    end

    // Stored code; detection above always uses the raw code
    always_comb begin
        w_store = io_kbd.rx_ascii;
`ifdef KEY_EVENT_CASE_FOLD_EN
        if (io_kbd.rx_ascii >= 8'h41 && io_kbd.rx_ascii <= 8'h5A) begin
            w_store = io_kbd.rx_ascii + 8'h20;
        end
`endif
    end

    // Edge detector history; updates through flush so held keys stay quiet
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prev_released <= 1'b1;
            r_prev_ascii    <= 8'h00;
        end else begin
            r_prev_released <= io_kbd.rx_released;
            r_prev_ascii    <= io_kbd.rx_ascii;
        end
    end

    // FIFO pointers, occupancy and sticky overflow
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (io_kbd.flush) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CNT_W'(1);
            end
            if (w_press && !w_push) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Entry storage; reset wipes contents so nothing survives a reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= 8'h00;
            end
        end else if (!io_kbd.flush && w_push) begin
            r_mem[r_wr_ptr] <= w_store;
        end
    end

    // Outputs depend only on registered state
    assign io_kbd.ev_valid = !w_empty;
    assign io_kbd.ev_ascii = w_empty ? 8'h00 : r_mem[r_rd_ptr];
    assign io_kbd.count    = r_count;
    assign io_kbd.overflow = r_overflow;

endmodule
